// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared types and constants for the inst/data SRAM-like port arbiter.
package cpu_sram_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE_W = 2;

  // Source tag stored in the in-order response ID FIFO
  typedef logic src_id_t;
  localparam src_id_t SRC_INST = 1'b0;
  localparam src_id_t SRC_DATA = 1'b1;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Address-phase payload of one SRAM-like request
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_fields_t;

  // Request payload of whichever requester holds the grant
  function automatic req_fields_t pick_req(input logic        sel_data,
                                           input req_fields_t inst_f,
                                           input req_fields_t data_f);
    return sel_data ? data_f : inst_f;
  endfunction

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// One SRAM-like port: request/address phase plus in-order data response.
interface cpu_sram_arbiter_if;
  import cpu_sram_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addrok;
  logic              dataok;
  logic [DATA_W-1:0] rdata;

  // Issues requests, receives handshakes and responses
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addrok, dataok, rdata
  );

  // Receives requests, returns handshakes and responses
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addrok, dataok, rdata
  );

endinterface

// File: rtl/cpu_sram_arbiter_arb_id_fifo.sv
// Small in-order FIFO of 1-bit source IDs for requests awaiting a response.
module arb_id_fifo
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  src_id_t din_i,
  input  logic    pop_i,
  output src_id_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  src_id_t          ids_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = ids_q[rd_ptr_q];

  // Overflow/underflow requests are dropped rather than corrupting state
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; pointers wrap on power-of-2 depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ids_q[i] <= SRC_INST;
    end else if (push_ok) begin
      ids_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Merges inst and data SRAM-like ports onto one master port; data wins
// arbitration unless inst has waited through DATA_STREAK data grants.
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DATA_STREAK     = 4
) (
  input  logic                clk,
  input  logic                reset,
  cpu_sram_arbiter_if.slave   inst,
  cpu_sram_arbiter_if.slave   data,
  cpu_sram_arbiter_if.master  mem
);

  localparam int unsigned STREAK_W = $clog2(DATA_STREAK + 1);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_sat_c;
  logic                sel_data_c, sel_inst_c;
  logic                mem_req_c, accept_c, pop_c;
  src_id_t             push_id_c;
  src_id_t             fifo_head;
  logic                fifo_full, fifo_empty;
  req_fields_t         inst_f, data_f, sel_f;

  // Grant: data first, unless inst has been passed over DATA_STREAK times
  assign streak_sat_c = (streak_q == STREAK_W'(DATA_STREAK));
  assign sel_data_c   = data.req & ~(inst.req & streak_sat_c);
  assign sel_inst_c   = ~sel_data_c & inst.req;

  assign inst_f = '{wr: inst.wr, size: inst.size, addr: inst.addr,
                    wstrb: inst.wstrb, wdata: inst.wdata};
  assign data_f = '{wr: data.wr, size: data.size, addr: data.addr,
                    wstrb: data.wstrb, wdata: data.wdata};
  assign sel_f  = pick_req(sel_data_c, inst_f, data_f);

  // No bypass: a full FIFO blocks the request even if a pop happens this cycle
  assign mem_req_c = (inst.req | data.req) & ~fifo_full & ~reset;
  assign accept_c  = mem_req_c & mem.addrok;
  assign push_id_c = sel_data_c ? SRC_DATA : SRC_INST;

  assign mem.req   = mem_req_c;
  assign mem.wr    = sel_f.wr;
  assign mem.size  = sel_f.size;
  assign mem.addr  = sel_f.addr;
  assign mem.wstrb = sel_f.wstrb;
  assign mem.wdata = sel_f.wdata;

  assign inst.addrok = accept_c & sel_inst_c;
  assign data.addrok = accept_c & sel_data_c;

  // Response demux: head of the ID FIFO names the owner of this dataok
  assign pop_c       = mem.dataok & ~fifo_empty & ~reset;
  assign inst.dataok = pop_c & (fifo_head == SRC_INST);
  assign data.dataok = pop_c & (fifo_head == SRC_DATA);
  assign inst.rdata  = mem.rdata;
  assign data.rdata  = mem.rdata;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (accept_c),
    .din_i   (push_id_c),
    .pop_i   (pop_c),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Streak of data grants taken while inst waits; any inst grant or idle inst clears it
  always_comb begin
    streak_d = streak_q;
    if (!inst.req) begin
      streak_d = '0;
    end else if (accept_c && sel_inst_c) begin
      streak_d = '0;
    end else if (accept_c && sel_data_c && !streak_sat_c) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // Streak register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  // A response with nothing outstanding is a master protocol error; it is dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem.dataok && fifo_empty))
        else $warning("cpu_sram_arbiter: mem_dataok with no outstanding request ignored");
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed, table-driven bench for cpu_sram_arbiter.
module tb_cpu_sram_arbiter;
  import cpu_sram_arbiter_pkg::*;

  localparam logic [31:0] IADDR  = 32'hBFC0_0000;
  localparam logic [31:0] DADDR  = 32'h8000_0100;
  localparam logic [31:0] DWDATA = 32'hDEAD_BEEF;

  logic clk;
  logic rst;

  cpu_sram_arbiter_if inst_if ();
  cpu_sram_arbiter_if data_if ();
  cpu_sram_arbiter_if mem_if ();

  cpu_sram_arbiter #(
    .MAX_OUTSTANDING (4),
    .DATA_STREAK     (4)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .inst  (inst_if),
    .data  (data_if),
    .mem   (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        e_mreq, e_sel, e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic vec_t mk(input logic r, ir, dr, ak, dk, input logic [31:0] rd,
                              input logic em, es, eia, eda, eid, edd);
    vec_t v;
    v.rst = r; v.ireq = ir; v.dreq = dr; v.aok = ak; v.dok = dk; v.rdata = rd;
    v.e_mreq = em; v.e_sel = es; v.e_iaok = eia; v.e_daok = eda;
    v.e_idok = eid; v.e_ddok = edd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, ir, dr, ak, dk, input logic [31:0] rd);
    rst            = r;
    inst_if.req    = ir;
    data_if.req    = dr;
    mem_if.addrok  = ak;
    mem_if.dataok  = dk;
    mem_if.rdata   = rd;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    req_fields_t exp_f, act_f;
    exp_f = v.e_sel ? '{wr: 1'b1, size: SIZE_HALF, addr: DADDR, wstrb: 4'b0011, wdata: DWDATA}
                    : '{wr: 1'b0, size: SIZE_WORD, addr: IADDR, wstrb: 4'b0000, wdata: 32'h0};
    act_f = '{wr: mem_if.wr, size: mem_if.size, addr: mem_if.addr,
              wstrb: mem_if.wstrb, wdata: mem_if.wdata};
    chk("mem_req",     idx, 128'(mem_if.req),     128'(v.e_mreq));
    chk("inst_addrok", idx, 128'(inst_if.addrok), 128'(v.e_iaok));
    chk("data_addrok", idx, 128'(data_if.addrok), 128'(v.e_daok));
    chk("inst_dataok", idx, 128'(inst_if.dataok), 128'(v.e_idok));
    chk("data_dataok", idx, 128'(data_if.dataok), 128'(v.e_ddok));
    if (v.e_mreq) chk("mem_fields", idx, 128'(act_f), 128'(exp_f));
    if (v.e_idok) chk("inst_rdata", idx, 128'(inst_if.rdata), 128'(v.rdata));
    if (v.e_ddok) chk("data_rdata", idx, 128'(data_if.rdata), 128'(v.rdata));
  endtask

  initial begin
    string grants;
    int    idok_cnt;

    inst_if.wr = 1'b0; inst_if.size = SIZE_WORD; inst_if.addr = IADDR;
    inst_if.wstrb = 4'b0000; inst_if.wdata = 32'h0;
    data_if.wr = 1'b1; data_if.size = SIZE_HALF; data_if.addr = DADDR;
    data_if.wstrb = 4'b0011; data_if.wdata = DWDATA;

    //            rst ir dr ak dk rdata          mreq sel iaok daok idok ddok
    // reset and idle
    vq.push_back(mk(1, 1, 1, 1, 1, 32'h0,         0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    // inst held without addrok, then single inst read
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h3C08_0001, 0, 0, 0, 0, 1, 0));
    // simultaneous requests: data first, then inst; responses in order
    vq.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hAAAA_0002, 0, 0, 0, 0, 1, 0));
    // streak: D,D,D,D,I,D,D,D,D,I with push+pop each cycle after the first
    vq.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0001, 1, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0002, 1, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0003, 1, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0004, 1, 0, 1, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0005, 1, 1, 0, 1, 1, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0006, 1, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0007, 1, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0008, 1, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 1, 32'hB000_0009, 1, 0, 1, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hB000_000A, 0, 0, 0, 0, 1, 0));
    // fill to MAX_OUTSTANDING, blocked while full, one pop, resume next cycle
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 32'hC000_0001, 0, 1, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hC000_0002, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hC000_0003, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hC000_0004, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hC000_0005, 0, 0, 0, 0, 0, 1));
    // interleaved I,D,I with responses routed by source
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0011, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0022, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0033, 0, 0, 0, 0, 1, 0));
    // reset with 3 outstanding; stray dataok after release is dropped
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 1, 32'h0000_0055, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0066, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0044, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].ireq, vq[i].dreq, vq[i].aok, vq[i].dok, vq[i].rdata);
      #2;
      check_vec(vq[i], i);
      @(posedge clk);
      #1;
    end

    // Hand sequence: grant pattern under continuous contention
    grants   = "";
    idok_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, (i > 0), 32'(i));
      #2;
      if (data_if.addrok)      grants = {grants, "D"};
      else if (inst_if.addrok) grants = {grants, "I"};
      else                     grants = {grants, "-"};
      if (inst_if.dataok) idok_cnt++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (grants != "DDDDIDDDDI") begin
      n_mis++;
      $display("FAIL grant_seq: got %s expected DDDDIDDDDI", grants);
    end
    chk("seq_inst_dataok_cnt", 100, 128'(idok_cnt), 128'(1));

    // Drain the last inst grant
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077);
    #2;
    chk("drain_inst_dataok", 101, 128'(inst_if.dataok), 128'(1'b1));
    chk("drain_data_dataok", 101, 128'(data_if.dataok), 128'(1'b0));
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("idle_mem_req", 102, 128'(mem_if.req), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
